// File: rtl/part_wwr_ram_sync.sv
// Latched-address write-while-read RAM with per-bit write enables.
// Post-reset clear sequencer and sticky out-of-range write flag.
module part_wwr_ram_sync #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] we_n,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  wr_err
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic [ADDR_WIDTH-1:0] ea;
  logic                  in_range;
  logic                  wr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;

  // Flow-through latch: a ce cycle already uses the new address.
  always_comb begin
    ea       = ce ? addr : addr_reg;
    in_range = {1'b0, ea} < DEPTH_L;
    wr       = ce && (we_n != '1);
    old_word = in_range ? ram[ea] : '0;
    merged   = (din & ~we_n) | (old_word & we_n);
    rd_word  = '0;
    if (in_range)
      rd_word = (BYPASS != 0 && wr) ? merged : old_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      busy     <= 1'b1;
      clr_ptr  <= '0;
      addr_reg <= '0;
      dout     <= '0;
      wr_err   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (ce)
            addr_reg <= addr;
          if (wr && !in_range)
            wr_err <= 1'b1;
          if (strobe)
            dout <= rd_word;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Array has no reset; the sequencer gives it defined contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        ram[clr_ptr] <= '0;
      else if (wr && in_range)
        ram[ea] <= merged;
    end
  end

endmodule

// File: tb/tb_part_wwr_ram_sync.sv
// Directed bench for part_wwr_ram_sync: bypass, no-bypass
// and reduced-depth builds share one stimulus stream.
module tb_part_wwr_ram_sync;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       ce     = 1'b0;
  logic [4:0] addr   = '0;
  logic       strobe = 1'b0;
  logic [1:0] din    = '0;
  logic [1:0] we_n   = 2'b11;

  logic [1:0] dout_a, dout_b, dout_c;
  logic       busy_a, busy_b, busy_c;
  logic       err_a, err_b, err_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  part_wwr_ram_sync #(.BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .ce(ce), .addr(addr),
    .strobe(strobe), .din(din), .we_n(we_n),
    .dout(dout_a), .busy(busy_a), .wr_err(err_a)
  );

  part_wwr_ram_sync #(.BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .ce(ce), .addr(addr),
    .strobe(strobe), .din(din), .we_n(we_n),
    .dout(dout_b), .busy(busy_b), .wr_err(err_b)
  );

  part_wwr_ram_sync #(.DEPTH(20)) u_c (
    .clk(clk), .reset(reset), .ce(ce), .addr(addr),
    .strobe(strobe), .din(din), .we_n(we_n),
    .dout(dout_c), .busy(busy_c), .wr_err(err_c)
  );

  always @(posedge clk) begin
    if (!reset)
      assert (!$isunknown(addr) && !$isunknown(we_n))
        else $error("X on addr or we_n");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce     = 1'b0;
    strobe = 1'b0;
    we_n   = 2'b11;
    din    = '0;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [1:0] d,
                    input logic [1:0] m);
    ce = 1'b1; addr = a; din = d;
    we_n = m; strobe = 1'b0;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] a);
    ce = 1'b1; addr = a; strobe = 1'b1;
    we_n = 2'b11;
    tick();
    idle();
  endtask

  task automatic clear_run(input string tag);
    int fa, fc, bad;
    fa = 0; fc = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 15) begin
        ce = 1'b1; addr = 5'd5; din = 2'b11;
        we_n = 2'b00; strobe = 1'b1;
      end else begin
        idle();
      end
      tick();
      if (!busy_a && fa == 0) fa = i;
      if (!busy_c && fc == 0) fc = i;
      if (busy_a && dout_a != 0) bad++;
      if (busy_c && dout_c != 0) bad++;
    end
    idle();
    chk({tag, "_busy32"}, fa, 32);
    chk({tag, "_busy20"}, fc, 20);
    chk({tag, "_dout0"}, bad, 0);
    chk({tag, "_err"}, {err_a, err_b, err_c}, 0);
  endtask

  initial begin
    int bad;
    logic [1:0] e;

    tick(); tick();
    chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b111);
    chk("rst_dout", {dout_a, dout_b, dout_c}, 0);
    chk("rst_err", {err_a, err_b, err_c}, 0);

    reset = 1'b0;
    clear_run("clr");

    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      if (dout_a != 0 || dout_b != 0 || dout_c != 0)
        bad++;
    end
    chk("clr_words", bad, 0);

    wr(5'd5, 2'b10, 2'b00);
    strobe = 1'b1; addr = 5'd0;
    tick();
    chk("rd_latched", dout_a, 2'b10);
    ce = 1'b1; addr = 5'd6;
    tick();
    chk("rd_flow", dout_a, 2'b00);
    ce = 1'b0; addr = 5'd5;
    tick();
    chk("rd_ce0", dout_a, 2'b00);
    rd(5'd5);
    chk("rd5", dout_c, 2'b10);
    ce = 1'b1; addr = 5'd6; strobe = 1'b0;
    tick();
    idle();
    chk("hold", dout_a, 2'b10);

    wr(5'd9, 2'b11, 2'b00);
    wr(5'd9, 2'b00, 2'b10);
    rd(5'd9);
    chk("mask", dout_a, 2'b10);
    wr(5'd9, 2'b00, 2'b11);
    rd(5'd9);
    chk("mask_none", dout_a, 2'b10);
    chk("mask_err", err_a, 1'b0);
    ce = 1'b0; din = 2'b01; we_n = 2'b00;
    tick();
    idle();
    rd(5'd9);
    chk("wr_ce0", dout_b, 2'b10);

    wr(5'd3, 2'b01, 2'b00);
    ce = 1'b1; addr = 5'd3; din = 2'b10;
    we_n = 2'b00; strobe = 1'b1;
    tick();
    idle();
    chk("wwr_byp", dout_a, 2'b10);
    chk("wwr_nobyp", dout_b, 2'b01);
    chk("wwr_d20", dout_c, 2'b10);
    rd(5'd3);
    chk("wwr_after", {dout_a, dout_b}, 4'b1010);

    wr(5'd25, 2'b11, 2'b00);
    chk("oor_err", err_c, 1'b1);
    chk("oor_err32", err_a, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      e = (i == 3 || i == 5 || i == 9) ? 2'b10 : 2'b00;
      rd(5'(i));
      if (dout_c != e) bad++;
    end
    chk("oor_array", bad, 0);
    rd(5'd3);
    rd(5'd25);
    chk("oor_rd", dout_c, 2'b00);
    chk("oor_rd32", dout_a, 2'b11);
    tick(); tick(); tick();
    chk("oor_sticky", err_c, 1'b1);

    reset = 1'b1;
    tick();
    chk("rst_clr_err", err_c, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    ce = 1'b1; addr = 5'd30; din = 2'b11; we_n = 2'b00;
    tick();
    idle();
    chk("mid_busy", {busy_a, busy_c}, 2'b11);
    reset = 1'b0;
    clear_run("rclr");
    rd(5'd5);
    chk("rclr_rd5", {dout_a, dout_b, dout_c}, 0);
    rd(5'd30);
    chk("rclr_rd30", {dout_a, dout_b}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
